// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter for the register file write port, shared by two requesters,
// with a built-in sequencer that zeroes every register, one per cycle.
module regfile_wr_arbiter #(
   parameter int AW      = 5,
   parameter int DW      = 32,
   parameter int NREG    = 32,
   parameter bit R0_ZERO = 1'b1
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          req0_valid,
   input  logic [AW-1:0] req0_addr,
   input  logic [DW-1:0] req0_data,
   output logic          req0_ready,
   input  logic          req1_valid,
   input  logic [AW-1:0] req1_addr,
   input  logic [DW-1:0] req1_data,
   output logic          req1_ready,
   input  logic          clr_start,
   output logic          clr_busy,
   output logic          clr_done,
   output logic          rf_we,
   output logic [AW-1:0] rf_waddr,
   output logic [DW-1:0] rf_wdata,
   output logic [1:0]    grant_id
);

   typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

   // cnt is the next clear address to issue; one extra bit lets it reach NREG
   localparam logic [AW:0] LAST = (AW+1)'(NREG);

   state_t        state, state_nxt;
   logic [AW:0]   cnt, cnt_nxt;
   logic          last_grant, last_grant_nxt;
   logic          gnt0, gnt1;
   logic          issue, issue_we;
   logic [AW-1:0] issue_addr;
   logic [DW-1:0] issue_data;
   logic [1:0]    issue_id;

   // last_grant==1 means req0 wins the next tie
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (state == IDLE) begin
         if (req0_valid && req1_valid) begin
            gnt0 = last_grant;
            gnt1 = !last_grant;
         end else begin
            gnt0 = req0_valid;
            gnt1 = req1_valid;
         end
      end
   end

   assign req0_ready = gnt0;
   assign req1_ready = gnt1;

   always_comb begin
      state_nxt      = state;
      cnt_nxt        = cnt;
      last_grant_nxt = last_grant;
      issue          = 1'b0;
      issue_we       = 1'b0;
      issue_addr     = '0;
      issue_data     = '0;
      issue_id       = 2'd0;
      case (state)
         IDLE: begin
            if (gnt0 || gnt1) begin
               issue          = 1'b1;
               issue_addr     = gnt1 ? req1_addr : req0_addr;
               issue_data     = gnt1 ? req1_data : req0_data;
               issue_id       = gnt1 ? 2'd1 : 2'd0;
               issue_we       = !(R0_ZERO && (issue_addr == '0));
               last_grant_nxt = gnt1;
            end
            if (clr_start) begin
               state_nxt = CLEAR;
               // with an idle port the first clear write goes out immediately
               if (!(gnt0 || gnt1)) begin
                  issue    = 1'b1;
                  issue_we = 1'b1;
                  issue_id = 2'd2;
                  cnt_nxt  = (AW+1)'(1);
               end
            end
         end
         CLEAR: begin
            if (cnt == LAST) begin
               state_nxt = DONE;
               cnt_nxt   = '0;
            end else begin
               issue      = 1'b1;
               issue_we   = 1'b1;
               issue_addr = cnt[AW-1:0];
               issue_id   = 2'd2;
               cnt_nxt    = cnt + (AW+1)'(1);
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state      <= IDLE;
         cnt        <= '0;
         last_grant <= 1'b1;
         rf_we      <= 1'b0;
         rf_waddr   <= '0;
         rf_wdata   <= '0;
         grant_id   <= 2'd0;
         clr_busy   <= 1'b0;
         clr_done   <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         last_grant <= last_grant_nxt;
         rf_we      <= issue_we;
         if (issue) begin
            rf_waddr <= issue_addr;
            rf_wdata <= issue_data;
            grant_id <= issue_id;
         end
         clr_busy   <= (state_nxt == CLEAR);
         clr_done   <= (state_nxt == DONE);
      end
   end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter: arbitration order, r0 suppression,
// clear sequencing and reset during a clear.
module tb_regfile_wr_arbiter;

   logic        Clk, Reset;
   logic        req0_valid, req1_valid, req0_ready, req1_ready;
   logic [4:0]  req0_addr, req1_addr, rf_waddr;
   logic [31:0] req0_data, req1_data, rf_wdata;
   logic        clr_start, clr_busy, clr_done, rf_we;
   logic [1:0]  grant_id;

   int n_chk = 0;
   int n_pass = 0;

   regfile_wr_arbiter dut (
      .Clk(Clk), .Reset(Reset),
      .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
      .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .grant_id(grant_id)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      tick();
      tick();
      Reset = 1'b0;
   endtask

   initial begin
      Reset = 1'b1;
      req0_valid = 0; req0_addr = 0; req0_data = 0;
      req1_valid = 0; req1_addr = 0; req1_data = 0;
      clr_start = 0;
      tick();
      tick();
      chk("rst_outs", {rf_we, rf_waddr, rf_wdata, grant_id, clr_busy, clr_done}, 64'd0);
      Reset = 1'b0;

      // single req0 write, 1-cycle latency
      req0_valid = 1; req0_addr = 5'd3; req0_data = 32'h8000_1111;
      #1;
      chk("t1_rdy", {req0_ready, req1_ready}, 2'b10);
      tick();
      req0_valid = 0;
      chk("t1_wr", {rf_we, grant_id, rf_waddr, rf_wdata}, {1'b1, 2'd0, 5'd3, 32'h8000_1111});

      // tie from reset: req0 first, then alternating, no bubbles
      do_reset();
      req0_valid = 1; req0_addr = 5'd1; req0_data = 32'hA1;
      req1_valid = 1; req1_addr = 5'd2; req1_data = 32'hB2;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("t2_rdy", {req0_ready, req1_ready}, (k % 2 == 0) ? 2'b10 : 2'b01);
         tick();
         chk("t2_wr", {rf_we, grant_id, rf_waddr},
             (k % 2 == 0) ? {1'b1, 2'd0, 5'd1} : {1'b1, 2'd1, 5'd2});
      end
      req0_valid = 0; req1_valid = 0;

      // req0 wins alone so req1 is owed the next tie; the r0 write must flip that
      req0_valid = 1; req0_addr = 5'd7; req0_data = 32'h77;
      tick();
      req0_valid = 0;
      req1_valid = 1; req1_addr = 5'd0; req1_data = 32'h7FFF_FFFF;
      #1;
      chk("t3_rdy", {req0_ready, req1_ready}, 2'b01);
      tick();
      req1_valid = 0;
      chk("t3_r0_we", rf_we, 1'b0);
      req0_valid = 1; req0_addr = 5'd1; req0_data = 32'hC3;
      req1_valid = 1; req1_addr = 5'd2; req1_data = 32'hD4;
      #1;
      chk("t3_tie", {req0_ready, req1_ready}, 2'b10);
      tick();
      req0_valid = 0; req1_valid = 0;
      chk("t3_tie_wr", {rf_we, grant_id, rf_waddr, rf_wdata}, {1'b1, 2'd0, 5'd1, 32'hC3});

      // clear with req0 waiting behind it
      clr_start = 1;
      tick();
      clr_start = 0;
      req0_valid = 1; req0_addr = 5'd9; req0_data = 32'h55;
      for (int i = 0; i < 32; i++) begin
         chk("t4_clr", {rf_we, grant_id, rf_waddr, rf_wdata, req0_ready, req1_ready, clr_busy, clr_done},
             {1'b1, 2'd2, 5'(i), 32'd0, 1'b0, 1'b0, 1'b1, 1'b0});
         tick();
      end
      chk("t4_done", {rf_we, req0_ready, clr_busy, clr_done}, 4'b0001);
      tick();
      chk("t4_idle", {req0_ready, clr_busy, clr_done}, 3'b100);
      tick();
      req0_valid = 0;
      chk("t4_req0", {rf_we, grant_id, rf_waddr, rf_wdata}, {1'b1, 2'd0, 5'd9, 32'h55});

      // clear and req1 in the same cycle; restart attempt mid-clear
      clr_start = 1;
      req1_valid = 1; req1_addr = 5'd5; req1_data = 32'hABCD;
      #1;
      chk("t5_rdy", {req0_ready, req1_ready}, 2'b01);
      tick();
      clr_start = 0; req1_valid = 0;
      chk("t5_req1", {rf_we, grant_id, rf_waddr, rf_wdata, clr_busy}, {1'b1, 2'd1, 5'd5, 32'hABCD, 1'b1});
      tick();
      for (int i = 0; i < 32; i++) begin
         chk("t5_clr", {rf_we, grant_id, rf_waddr, rf_wdata, clr_busy}, {1'b1, 2'd2, 5'(i), 32'd0, 1'b1});
         clr_start = (i == 10);
         tick();
      end
      clr_start = 0;
      chk("t5_done", {rf_we, clr_busy, clr_done}, 3'b001);
      tick();
      chk("t5_idle", {rf_we, clr_busy, clr_done}, 3'b000);

      // reset lands mid-clear; the next clear starts over from address 0
      clr_start = 1;
      tick();
      clr_start = 0;
      repeat (12) tick();
      chk("t6_at12", {rf_we, rf_waddr}, {1'b1, 5'd12});
      Reset = 1;
      #1;
      chk("t6_rst", {rf_we, rf_waddr, rf_wdata, grant_id, clr_busy, clr_done}, 64'd0);
      tick();
      Reset = 0;
      tick();
      chk("t6_noresume", {rf_we, clr_busy}, 2'b00);
      clr_start = 1;
      tick();
      clr_start = 0;
      chk("t6_restart0", {rf_we, grant_id, rf_waddr, clr_busy}, {1'b1, 2'd2, 5'd0, 1'b1});
      tick();
      chk("t6_restart1", {rf_we, rf_waddr}, {1'b1, 5'd1});

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
